m_gate_checker: RTL and testbench
=================================

Name: m_gate_checker

Overview:
Self-contained stimulus/response checker for single-output combinational gates (m_OR_gate and siblings). On start it drives every input combination, 0 to 2^N_IN-1, onto the gate under test and waits a settle interval. It then samples the gate's output and compares it against a built-in golden function. It reports a mismatch count, the first failing vector and a pass flag, so a bench no longer has to read displayed truth tables by hand.

Parameters:
N_IN, 2, number of gate inputs; legal 1..8.
SETTLE, 1, cycles between driving a vector and sampling the response; legal 1..15.
OP, 1, golden function: 0 = AND, 1 = OR, 2 = XOR, 3 = NAND, 4 = NOR; reduction over all N_IN bits.

Ports:
w_clk  input  1  clock; all state updates on the rising edge.
w_rst  input  1  synchronous, active-high reset.
w_start  input  1  begin a run; sampled only in IDLE.
w_dut_out  input  1  output of the gate under test.
r_dut_in  output  N_IN  input vector driven to the gate under test.
r_busy  output  1  high while a run is in progress.
r_done  output  1  high from end of run until the next accepted start or reset.
r_pass  output  1  valid when r_done = 1; 1 means zero mismatches.
r_err_cnt  output  N_IN+1  number of mismatching vectors in the current or last run.
r_err_valid  output  1  r_first_err holds a captured vector.
r_first_err  output  N_IN  first vector whose response mismatched.

Behaviour:
- Clock and reset: one clock, w_clk. Reset w_rst is synchronous and active-high.
- Reset (any state, including mid-run):
  - State returns to IDLE.
  - All outputs go to 0: r_dut_in, r_busy, r_done, r_pass, r_err_cnt, r_err_valid, r_first_err.
  - The settle counter clears.
- States: IDLE, WAIT, SAMPLE.
- IDLE, w_start = 1, at the edge:
  - r_dut_in <= 0, r_busy <= 1.
  - r_done, r_pass, r_err_cnt, r_err_valid, r_first_err all <= 0.
  - Settle counter <= 0; go to WAIT.
- IDLE, w_start = 0: hold all outputs.
- WAIT:
  - If settle counter = SETTLE-1, go to SAMPLE.
  - Otherwise increment the counter.
  - r_dut_in is stable throughout.
- SAMPLE (one cycle):
  - Compute expected = OP applied to r_dut_in, and compare with w_dut_out.
  - On mismatch: r_err_cnt <= r_err_cnt+1.
  - On mismatch with r_err_valid = 0: r_first_err <= r_dut_in, r_err_valid <= 1.
  - If r_dut_in is not all ones: r_dut_in <= r_dut_in+1, counter <= 0, go to WAIT.
  - If r_dut_in is all ones (last vector): go to IDLE, r_busy <= 0, r_done <= 1.
  - On the last vector, r_pass <= 1 only if the updated error count is 0. This includes the last vector's own comparison.
  - r_dut_in keeps its final value (all ones) after the run.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - If the start is accepted at edge k, r_done rises at edge k + 2^N_IN*(SETTLE+1).
- Width: r_err_cnt is N_IN+1 bits. It can reach 2^N_IN exactly and never wraps.
- w_start while busy: ignored; the run continues unaffected.
- w_start held high after r_done: a new run is accepted at the first IDLE edge, so r_done is high for exactly one cycle.
- w_dut_out is sampled only in SAMPLE; glitches during WAIT have no effect.

Test Plan:
1. Correct OR gate wired back, defaults (N_IN=2, SETTLE=1, OP=1), 1-cycle start
   -> r_dut_in steps 0,1,2,3, each for 2 cycles.
   -> r_done rises 8 cycles after start with r_pass=1, r_err_cnt=0, r_err_valid=0.
2. w_dut_out tied to 0, defaults
   -> r_err_cnt=3, r_first_err=2'b01, r_err_valid=1, r_pass=0.
3. AND gate wired back, OP=1
   -> mismatches at vectors 01 and 10 only.
   -> r_err_cnt=2, r_first_err=2'b01, r_pass=0.
4. Reset asserted 3 cycles after start
   -> next edge: all outputs 0, IDLE.
   -> a new start then completes a full 8-cycle run, and a fresh reset is not required.
5. w_start pulsed again mid-run, then held high after completion
   -> the mid-run pulse has no effect and the first done still lands at 8 cycles.
   -> with start held high, r_done pulses for exactly 1 cycle and the second run restarts at r_dut_in=0.
6. N_IN=3, SETTLE=3, OP=2, XOR gate wired back
   -> 8 vectors, each held 4 cycles; done at 32 cycles, r_pass=1.
   -> w_dut_out forced to 1 -> r_err_cnt=4, r_first_err=3'b000.

Source files
------------

// File: rtl/m_gate_checker.sv
// Exhaustive stimulus/response checker for single-output combinational gates.
// Walks every input vector, waits a settle interval, and compares the gate output with a golden reduction.
module m_gate_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1,
    parameter int OP     = 1
) (
    input  logic            w_clk,
    input  logic            w_rst,
    input  logic            w_start,
    input  logic            w_dut_out,
    output logic [N_IN-1:0] r_dut_in,
    output logic            r_busy,
    output logic            r_done,
    output logic            r_pass,
    output logic [N_IN:0]   r_err_cnt,
    output logic            r_err_valid,
    output logic [N_IN-1:0] r_first_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    localparam logic [2:0] OP_SEL      = 3'(OP);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_ZERO = {N_IN{1'b0}};
    localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1'b1);
    localparam logic [N_IN:0]   CNT_ZERO = {(N_IN+1){1'b0}};
    localparam logic [N_IN:0]   CNT_ONE  = (N_IN+1)'(1'b1);

    state_t      state_r;
    logic [3:0]  settle_cnt_r;
    logic        expected_s;
    logic        mismatch_s;
    logic        last_vec_s;
    logic [N_IN:0] err_cnt_next_s;

    // Golden reduction over the whole input vector.
    function automatic logic golden_fn(input logic [N_IN-1:0] vec);
        logic res;
        case (OP_SEL)
            3'd0:    res = &vec;
            3'd1:    res = |vec;
            3'd2:    res = ^vec;
            3'd3:    res = ~&vec;
            3'd4:    res = ~|vec;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Response comparison and the error count this sample would produce.
    always_comb begin
        expected_s = golden_fn(r_dut_in);
        mismatch_s = (expected_s != w_dut_out);
        last_vec_s = &r_dut_in;
        if (mismatch_s) begin
            err_cnt_next_s = r_err_cnt + CNT_ONE;
        end else begin
            err_cnt_next_s = r_err_cnt;
        end
    end

    // Run sequencer: IDLE -> (WAIT -> SAMPLE) per vector -> IDLE.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_r      <= ST_IDLE;
            settle_cnt_r <= 4'd0;
            r_dut_in     <= VEC_ZERO;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_cnt    <= CNT_ZERO;
            r_err_valid  <= 1'b0;
            r_first_err  <= VEC_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (w_start) begin
                        state_r      <= ST_WAIT;
                        settle_cnt_r <= 4'd0;
                        r_dut_in     <= VEC_ZERO;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_err_cnt    <= CNT_ZERO;
                        r_err_valid  <= 1'b0;
                        r_first_err  <= VEC_ZERO;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        state_r <= ST_SAMPLE;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    r_err_cnt <= err_cnt_next_s;
                    if (mismatch_s && !r_err_valid) begin
                        r_first_err <= r_dut_in;
                        r_err_valid <= 1'b1;
                    end
                    // The final vector leaves r_dut_in at all ones for inspection.
                    if (last_vec_s) begin
                        state_r <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (err_cnt_next_s == CNT_ZERO);
                    end else begin
                        state_r      <= ST_WAIT;
                        settle_cnt_r <= 4'd0;
                        r_dut_in     <= r_dut_in + VEC_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_gate_checker.sv
// Scoreboard bench for m_gate_checker: default 2-input OR checker plus a 3-input XOR checker.
module tb_m_gate_checker;

    typedef struct {
        int err_cnt;
        int err_valid;
        int first_err;
        int pass;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    int start0_cyc = 0;
    int start1_cyc = 0;

    // DUT 0: defaults
    logic       rst = 1'b1, start0 = 1'b0, out0;
    logic [1:0] din0, ferr0;
    logic [2:0] ecnt0;
    logic       busy0, done0, pass0, evld0;
    int         mode0 = 0;  // 0 = OR gate, 1 = stuck at 0, 2 = AND gate
    assign out0 = (mode0 == 0) ? |din0 : (mode0 == 1) ? 1'b0 : &din0;

    // DUT 1: 3 inputs, settle 3, XOR
    logic       start1 = 1'b0, out1;
    logic [2:0] din1, ferr1;
    logic [3:0] ecnt1;
    logic       busy1, done1, pass1, evld1;
    int         mode1 = 0;  // 0 = XOR gate, 1 = stuck at 1
    assign out1 = (mode1 == 0) ? ^din1 : 1'b1;

    m_gate_checker #(.N_IN(2), .SETTLE(1), .OP(1)) u_dut0 (
        .w_clk(clk), .w_rst(rst), .w_start(start0), .w_dut_out(out0),
        .r_dut_in(din0), .r_busy(busy0), .r_done(done0), .r_pass(pass0),
        .r_err_cnt(ecnt0), .r_err_valid(evld0), .r_first_err(ferr0)
    );

    m_gate_checker #(.N_IN(3), .SETTLE(3), .OP(2)) u_dut1 (
        .w_clk(clk), .w_rst(rst), .w_start(start1), .w_dut_out(out1),
        .r_dut_in(din1), .r_busy(busy1), .r_done(done1), .r_pass(pass1),
        .r_err_cnt(ecnt1), .r_err_valid(evld1), .r_first_err(ferr1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int e, input int v, input int f, input int p, input int l);
        exp_t x;
        x.err_cnt = e; x.err_valid = v; x.first_err = f; x.pass = p; x.lat = l;
        return x;
    endfunction

    // Monitors: pop one expectation on each rising r_done.
    logic done0_prev = 1'b0;
    always @(negedge clk) begin
        exp_t x;
        if (done0 && !done0_prev) begin
            if (q0.size() == 0) begin
                chk("dut0_unexpected_done", 1, 0);
            end else begin
                x = q0.pop_front();
                chk("dut0_latency", cyc - start0_cyc, x.lat);
                chk("dut0_err_cnt", int'(ecnt0), x.err_cnt);
                chk("dut0_err_valid", int'(evld0), x.err_valid);
                chk("dut0_first_err", int'(ferr0), x.first_err);
                chk("dut0_pass", int'(pass0), x.pass);
                chk("dut0_busy_at_done", int'(busy0), 0);
            end
        end
        done0_prev = done0;
    end

    logic done1_prev = 1'b0;
    always @(negedge clk) begin
        exp_t x;
        if (done1 && !done1_prev) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_done", 1, 0);
            end else begin
                x = q1.pop_front();
                chk("dut1_latency", cyc - start1_cyc, x.lat);
                chk("dut1_err_cnt", int'(ecnt1), x.err_cnt);
                chk("dut1_err_valid", int'(evld1), x.err_valid);
                chk("dut1_first_err", int'(ferr1), x.first_err);
                chk("dut1_pass", int'(pass1), x.pass);
            end
        end
        done1_prev = done1;
    end

    // One-cycle start pulse; records the edge that accepted it.
    task automatic pulse_start(input int which);
        @(negedge clk);
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        if (which == 0) start0_cyc = cyc; else start1_cyc = cyc;
        @(negedge clk);
        if (which == 0) start0 = 1'b0; else start1 = 1'b0;
    endtask

    task automatic wait_drain(input int which, input int budget);
        bool_loop: for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (which == 0 && q0.size() == 0) break;
            if (which == 1 && q1.size() == 0) break;
        end
        if (which == 0) chk("dut0_drain_timeout", q0.size(), 0);
        else            chk("dut1_drain_timeout", q1.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_din0", int'(din0), 0);
        chk("rst_flags0", int'({busy0, done0, pass0, evld0}), 0);
        chk("rst_cnt0", int'(ecnt0), 0);
        chk("rst_ferr0", int'(ferr0), 0);
        chk("rst_flags1", int'({busy1, done1, pass1, evld1, ecnt1, din1}), 0);

        // 1: correct OR gate, vector trace 0,0,1,1,2,2,3,3
        mode0 = 0;
        q0.push_back(mk(0, 0, 0, 1, 8));
        pulse_start(0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_din_c%0d", i), int'(din0), i / 2);
            chk($sformatf("t1_busy_c%0d", i), int'(busy0), 1);
            @(negedge clk);
        end
        wait_drain(0, 20);

        // 2: output stuck at 0
        mode0 = 1;
        q0.push_back(mk(3, 1, 1, 0, 8));
        pulse_start(0);
        wait_drain(0, 20);
        chk("t2_din_final", int'(din0), 3);

        // 3: AND gate against OR golden
        mode0 = 2;
        q0.push_back(mk(2, 1, 1, 0, 8));
        pulse_start(0);
        wait_drain(0, 20);

        // 4: reset mid-run, then a clean run
        mode0 = 0;
        pulse_start(0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_rst_din", int'(din0), 0);
        chk("t4_rst_flags", int'({busy0, done0, pass0, evld0}), 0);
        chk("t4_rst_cnt", int'({ecnt0, ferr0}), 0);
        rst = 1'b0;
        q0.push_back(mk(0, 0, 0, 1, 8));
        pulse_start(0);
        wait_drain(0, 20);

        // 5: mid-run start pulse ignored; held start restarts immediately
        q0.push_back(mk(0, 0, 0, 1, 8));
        q0.push_back(mk(0, 0, 0, 1, 8));
        pulse_start(0);
        repeat (2) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        start0 = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_done_high", int'(done0), 1);
        @(negedge clk);
        chk("t5_done_one_cycle", int'(done0), 0);
        chk("t5_restart_din", int'(din0), 0);
        chk("t5_restart_busy", int'(busy0), 1);
        start0_cyc = cyc;
        start0 = 1'b0;
        wait_drain(0, 30);

        // 6: 3-input XOR, settle 3
        mode1 = 0;
        q1.push_back(mk(0, 0, 0, 1, 32));
        pulse_start(1);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("t6_din_c%0d", i), int'(din1), i / 4);
            @(negedge clk);
        end
        wait_drain(1, 50);

        mode1 = 1;
        q1.push_back(mk(4, 1, 0, 0, 32));
        pulse_start(1);
        wait_drain(1, 50);
        chk("t6_din_final", int'(din1), 7);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
